// File: rtl/exu_redirect_ctrl.sv
// exu_redirect_ctrl: branch-mispredict flush/redirect sequencer between EXU and IFU
// Ports: i_clk/i_rst (async active-high); i_bju_vld,i_jump,i_jaddr,i_pc,i_pred_taken,i_pred_addr
// describe a resolving branch; i_trap_flush overrides everything; i_redirect_rdy accepts the redirect.
// o_flush kills younger pipe stages, o_redirect_vld/o_redirect_addr steer fetch, o_busy stalls branch issue.
// o_perf_br_cnt/o_perf_mis_cnt count accepted branches/mispredicts when REDIRECT_PERF_EN is defined, else tie to 0.
module exu_redirect_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_bju_vld,
  input  logic            i_jump,
  input  logic [XLEN-1:0] i_jaddr,
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_pred_taken,
  input  logic [XLEN-1:0] i_pred_addr,
  input  logic            i_trap_flush,
  input  logic            i_redirect_rdy,
  output logic            o_flush,
  output logic            o_redirect_vld,
  output logic [XLEN-1:0] o_redirect_addr,
  output logic            o_busy,
  output logic [31:0]     o_perf_br_cnt,
  output logic [31:0]     o_perf_mis_cnt
);
  typedef enum logic [1:0] {IDLE, FLUSH, REDIRECT} state_t;
  localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 1);
  state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic flush_q, flush_d, rvld_q, rvld_d, busy_q, busy_d;
  logic accept, mispred;
  logic [XLEN-1:0] target;
  // branches arriving while a redirect is in progress are dropped entirely
  assign accept = i_bju_vld & (state_q == IDLE);
  assign mispred = accept & ((i_jump != i_pred_taken) | (i_jump & i_pred_taken & (i_jaddr != i_pred_addr)));
  assign target = i_jump ? {i_jaddr[XLEN-1:1], 1'b0} : i_pc + XLEN'(4);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    if (i_trap_flush) begin
      state_d = IDLE;
      cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: if (mispred) begin
          state_d = FLUSH;
          cnt_d = CNT_INIT;
          addr_d = target;
        end
        FLUSH: begin
          state_d = (cnt_q == '0) ? REDIRECT : FLUSH;
          cnt_d = (cnt_q == '0) ? cnt_q : cnt_q - 3'd1;
        end
        REDIRECT: state_d = i_redirect_rdy ? IDLE : REDIRECT;
        default: state_d = IDLE;
      endcase
    end
    flush_d = state_d == FLUSH;
    rvld_d = state_d == REDIRECT;
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      addr_q <= '0;
      flush_q <= 1'b0;
      rvld_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      flush_q <= flush_d;
      rvld_q <= rvld_d;
      busy_q <= busy_d;
    end
  end
  assign o_flush = flush_q;
  assign o_redirect_vld = rvld_q;
  assign o_redirect_addr = addr_q;
  assign o_busy = busy_q;
`ifdef REDIRECT_PERF_EN
  logic [31:0] br_q, br_d, mis_q, mis_d;
  // mispredicts count even when a same-cycle trap discards them
  always_comb begin
    br_d = br_q + 32'(accept);
    mis_d = mis_q + 32'(mispred);
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      br_q <= '0;
      mis_q <= '0;
    end else begin
      br_q <= br_d;
      mis_q <= mis_d;
    end
  end
  assign o_perf_br_cnt = br_q;
  assign o_perf_mis_cnt = mis_q;
`else
  assign o_perf_br_cnt = '0;
  assign o_perf_mis_cnt = '0;
`endif
endmodule

// File: tb/tb_exu_redirect_ctrl.sv
// tb_exu_redirect_ctrl: directed stimulus with a cycle-timeline reference model and literal spot checks
module tb_exu_redirect_ctrl;
  localparam int FC = 2;
`ifdef REDIRECT_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  logic i_clk = 0, i_rst = 0;
  logic i_bju_vld = 0, i_jump = 0, i_pred_taken = 0, i_trap_flush = 0, i_redirect_rdy = 0;
  logic [31:0] i_jaddr = 0, i_pc = 0, i_pred_addr = 0;
  logic o_flush, o_redirect_vld, o_busy;
  logic [31:0] o_redirect_addr, o_perf_br_cnt, o_perf_mis_cnt;
  int checks = 0, errors = 0;
  exu_redirect_ctrl #(.FLUSH_CYCLES(FC), .XLEN(32)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_bju_vld(i_bju_vld), .i_jump(i_jump), .i_jaddr(i_jaddr),
    .i_pc(i_pc), .i_pred_taken(i_pred_taken), .i_pred_addr(i_pred_addr),
    .i_trap_flush(i_trap_flush), .i_redirect_rdy(i_redirect_rdy), .o_flush(o_flush),
    .o_redirect_vld(o_redirect_vld), .o_redirect_addr(o_redirect_addr), .o_busy(o_busy),
    .o_perf_br_cnt(o_perf_br_cnt), .o_perf_mis_cnt(o_perf_mis_cnt)
  );
  always #5 i_clk = ~i_clk;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask
  // model: a pending mispredict is remembered by the cycle it resolved in; outputs follow from elapsed cycles
  int cyc = 0, mis_cyc = -1;
  logic [31:0] m_addr = 0, m_br = 0, m_mis = 0, m_tgt;
  bit m_pend, m_redir, m_mp;
  always @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cyc = 0;
      mis_cyc = -1;
      m_addr = 0;
      m_br = 0;
      m_mis = 0;
    end else begin
      m_pend = mis_cyc >= 0;
      m_redir = m_pend && cyc > mis_cyc + FC;
      m_mp = i_bju_vld && ((i_jump != i_pred_taken) || (i_jump && i_jaddr != i_pred_addr));
      m_tgt = i_jump ? (i_jaddr & 32'hFFFF_FFFE) : i_pc + 32'd4;
      if (i_bju_vld && !m_pend) begin
        m_br = m_br + 1;
        if (m_mp) m_mis = m_mis + 1;
      end
      if (i_trap_flush) mis_cyc = -1;
      else if (m_redir && i_redirect_rdy) mis_cyc = -1;
      else if (!m_pend && m_mp) begin
        mis_cyc = cyc;
        m_addr = m_tgt;
      end
      cyc = cyc + 1;
    end
  end
  always @(negedge i_clk) begin
    chk("m_busy", 32'(o_busy), 32'(mis_cyc >= 0));
    chk("m_flush", 32'(o_flush), 32'(mis_cyc >= 0 && cyc <= mis_cyc + FC));
    chk("m_rvld", 32'(o_redirect_vld), 32'(mis_cyc >= 0 && cyc > mis_cyc + FC));
    chk("m_addr", o_redirect_addr, m_addr);
    chk("m_br", o_perf_br_cnt, PERF ? m_br : 32'd0);
    chk("m_mis", o_perf_mis_cnt, PERF ? m_mis : 32'd0);
  end
  task automatic drv(bit bju, bit j, logic [31:0] ja, logic [31:0] pc, bit pt, logic [31:0] pa, bit trap, bit rdy);
    i_bju_vld = bju;
    i_jump = j;
    i_jaddr = ja;
    i_pc = pc;
    i_pred_taken = pt;
    i_pred_addr = pa;
    i_trap_flush = trap;
    i_redirect_rdy = rdy;
  endtask
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask
  task automatic quiet();
    i_bju_vld = 0;
    i_trap_flush = 0;
  endtask
  initial begin
    #1 i_rst = 1;
    @(negedge i_clk);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_addr", o_redirect_addr, 0);
    #1 i_rst = 0;
    step();
    // taken mispredict, odd target has bit 0 cleared
    drv(1, 1, 32'h1003, 32'h100, 0, 0, 0, 1); step(); quiet();
    @(negedge i_clk); chk("s1_flush_a", 32'(o_flush), 1); chk("s1_busy_a", 32'(o_busy), 1); chk("s1_rvld_a", 32'(o_redirect_vld), 0);
    step(); @(negedge i_clk); chk("s1_flush_b", 32'(o_flush), 1);
    step(); @(negedge i_clk); chk("s1_flush_c", 32'(o_flush), 0); chk("s1_rvld_c", 32'(o_redirect_vld), 1); chk("s1_addr", o_redirect_addr, 32'h1002);
    step(); @(negedge i_clk); chk("s1_busy_d", 32'(o_busy), 0); chk("s1_rvld_d", 32'(o_redirect_vld), 0);
    // correct prediction: no activity
    drv(1, 1, 32'h500, 32'h40, 1, 32'h500, 0, 1); step(); quiet();
    @(negedge i_clk); chk("cp_busy", 32'(o_busy), 0); chk("cp_flush", 32'(o_flush), 0); chk("cp_addr", o_redirect_addr, 32'h1002);
    // not-taken mispredict at top of address space wraps
    drv(1, 0, 32'h0, 32'hFFFF_FFFC, 1, 32'h1234, 0, 1); step(); quiet();
    step(); step(); @(negedge i_clk); chk("wrap_rvld", 32'(o_redirect_vld), 1); chk("wrap_addr", o_redirect_addr, 32'h0);
    step();
    // target-mismatch mispredict with backpressure and an ignored second mispredict
    drv(1, 1, 32'h2000, 32'h80, 1, 32'h2004, 0, 0); step(); quiet();
    step(); step();
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk); chk("bp_rvld", 32'(o_redirect_vld), 1); chk("bp_addr", o_redirect_addr, 32'h2000);
      if (i == 1) drv(1, 1, 32'h3000, 32'h90, 0, 0, 0, 0);
      step(); quiet();
    end
    i_redirect_rdy = 1;
    @(negedge i_clk); chk("bp_rvld_end", 32'(o_redirect_vld), 1);
    step(); @(negedge i_clk); chk("bp_busy_done", 32'(o_busy), 0); chk("bp_addr_keep", o_redirect_addr, 32'h2000);
    // trap in the first redirect cycle, then trap racing a mispredict in idle
    drv(1, 1, 32'h4000, 32'h100, 0, 0, 0, 0); step(); quiet();
    step(); step(); @(negedge i_clk); chk("tr_rvld_a", 32'(o_redirect_vld), 1);
    drv(1, 0, 32'h0, 32'h200, 1, 0, 1, 0); step(); quiet();
    @(negedge i_clk); chk("tr_rvld_b", 32'(o_redirect_vld), 0); chk("tr_busy_b", 32'(o_busy), 0);
    drv(1, 1, 32'h5000, 32'h300, 0, 0, 1, 1); step(); quiet();
    @(negedge i_clk); chk("tr_flush_c", 32'(o_flush), 0); chk("tr_busy_c", 32'(o_busy), 0); chk("tr_addr_c", o_redirect_addr, 32'h4000);
    // trap mid-flush, then a fresh mispredict must run its full flush window
    drv(1, 1, 32'h6000, 32'h400, 0, 0, 0, 1); step(); quiet();
    @(negedge i_clk); chk("tf_flush_a", 32'(o_flush), 1);
    i_trap_flush = 1; step(); quiet();
    @(negedge i_clk); chk("tf_flush_b", 32'(o_flush), 0); chk("tf_busy_b", 32'(o_busy), 0);
    drv(1, 1, 32'h7000, 32'h500, 0, 0, 0, 1); step(); quiet();
    @(negedge i_clk); chk("tf_flush_c", 32'(o_flush), 1);
    step(); @(negedge i_clk); chk("tf_flush_d", 32'(o_flush), 1);
    step(); @(negedge i_clk); chk("tf_rvld_e", 32'(o_redirect_vld), 1); chk("tf_addr_e", o_redirect_addr, 32'h7000);
    step();
    // asynchronous reset between edges while flushing
    drv(1, 1, 32'h8000, 32'h600, 0, 0, 0, 1); step(); quiet();
    #2 i_rst = 1;
    #1 chk("ar_flush", 32'(o_flush), 0); chk("ar_rvld", 32'(o_redirect_vld), 0); chk("ar_busy", 32'(o_busy), 0);
    chk("ar_addr", o_redirect_addr, 0); chk("ar_br", o_perf_br_cnt, 0); chk("ar_mis", o_perf_mis_cnt, 0);
    @(negedge i_clk); #1 i_rst = 0;
    step();
    // perf: three correct predictions and one mispredict
    for (int i = 0; i < 3; i++) begin
      drv(1, 1, 32'h900 + 32'(i * 16), 32'h10, 1, 32'h900 + 32'(i * 16), 0, 1); step();
    end
    drv(1, 0, 32'h0, 32'hA00, 1, 32'hB00, 0, 1); step(); quiet();
    @(negedge i_clk); chk("pf_br", o_perf_br_cnt, PERF ? 32'd4 : 32'd0); chk("pf_mis", o_perf_mis_cnt, PERF ? 32'd1 : 32'd0);
    repeat (5) step();
    @(negedge i_clk); chk("pf_idle", 32'(o_busy), 0); chk("pf_addr", o_redirect_addr, 32'hA04);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
